uart_rx_frame: RTL and testbench
================================

// Module: uart_rx_frame
// PURPOSE
//  UART receive side of the image link. Deserialises 8N1 bytes from the host,
//  hunts for the 12-byte frame header "\n\nNew Img\r\n\n", then streams the next
//  FRAME_BYTES payload bytes out as pixels with a 1-cycle valid strobe.
//  Sits between the board RX pin and the frame-buffer write port.
// PARAMETERS
//  BAUD_DIV     104    clk cycles per bit (104 = 115200 baud @ 12 MHz); >= 4
//  FRAME_BYTES  19200  payload bytes per frame (160x120 x 8 bit)
//  TIMEOUT_CYC  65535  idle clk cycles tolerated inside payload (UART_RX_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, synchronous, active-high
//  rx           in   1   serial input, idle high, asynchronous to clk
//  pix_data     out  8   payload byte, valid when pix_valid=1
//  pix_valid    out  1   1-cycle strobe per payload byte
//  frame_start  out  1   1-cycle pulse, header fully matched
//  frame_done   out  1   1-cycle pulse, coincident with pix_valid of last byte
//  byte_count   out  16  payload bytes received in current frame
//  busy         out  1   1 while in PAYLOAD
//  rx_err       out  1   1-cycle pulse: framing error (or timeout, see CONFIGURATION)
// BEHAVIOUR
//  Reset: pix_data=0, pix_valid=0, frame_start=0, frame_done=0, byte_count=0,
//   busy=0, rx_err=0; sync FFs=1; bit FSM=IDLE; frame FSM=HUNT; hdr_idx=0.
//  rx passes a 2-FF synchroniser (rx_s); all logic uses rx_s only.
//  Bit FSM (baud counter 0..BAUD_DIV-1, bit counter 0..7):
//   IDLE  : rx_s=0 -> START, counter cleared.
//   START : at count BAUD_DIV/2 (integer) sample; 0 -> DATA; 1 -> IDLE (glitch).
//   DATA  : sample every BAUD_DIV cycles, LSB first; after bit 7 -> STOP.
//   STOP  : sample after BAUD_DIV; 1 -> byte_done strobe, IDLE;
//           0 -> rx_err pulse, byte discarded, wait for rx_s=1, then IDLE.
//  pix_valid/frame_start/frame_done/rx_err registered: assert the cycle after
//   the stop-bit sample. Back-to-back bytes with no idle gap must be accepted.
//  Frame FSM:
//   HUNT    : per byte_done compare with HDR[hdr_idx] (idx 0..11).
//             match -> hdr_idx+1; match at idx 11 -> frame_start, byte_count=0,
//             hdr_idx=0, -> PAYLOAD. Header bytes are never forwarded.
//             mismatch: byte="\n" -> hdr_idx = (hdr_idx==2) ? 2 : 1; else 0.
//   PAYLOAD : per byte_done -> pix_data=byte, pix_valid, byte_count+1.
//             byte_count reaching FRAME_BYTES -> frame_done, -> HUNT; byte_count
//             holds FRAME_BYTES until next frame_start clears it.
//             Header string appearing inside payload is data, not a resync.
//  Framing error: no pixel, byte_count unchanged, frame FSM state unchanged.
//  byte_count 16-bit; FRAME_BYTES <= 65535, never wraps.
//  rst mid-byte or mid-frame: immediate return to reset values; partial byte lost.
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined: idle counter runs in PAYLOAD, cleared per
//   byte_done; at TIMEOUT_CYC -> rx_err pulse, -> HUNT, byte_count kept for
//   debug, busy=0. Without it: no counter, PAYLOAD waits indefinitely.
// TESTING
//  1 Send "\n\nNew Img\r\n\n" then 0x00,0x55,0xAA,0xFF (FRAME_BYTES=4) ->
//    frame_start once, 4 pix_valid with those values, frame_done with 0xFF, busy 0.
//  2 Send "\n\n\nNew Img\r\n\n" + payload -> header still matched (idx stays 2).
//  3 Send "New Img\r\n\n" (no leading \n) + bytes -> no frame_start, no pix_valid.
//  4 Inside payload, byte 0x3C with stop bit forced 0 -> rx_err pulse, no pixel,
//    byte_count unchanged; next valid byte is counted.
//  5 rx low glitch of BAUD_DIV/4 cycles in IDLE -> no byte, no rx_err.
//  6 UART_RX_TIMEOUT_EN, TIMEOUT_CYC=500: stop after 2 payload bytes -> rx_err at
//    500 idle cycles, busy 0, byte_count=2; rst mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver that hunts for the "\n\nNew Img\r\n\n" header and
// streams the following FRAME_BYTES bytes out as pixels. Optional payload timeout: UART_RX_TIMEOUT_EN.
module uart_rx_frame #(
    parameter int BAUD_DIV    = 104,
    parameter int FRAME_BYTES = 19200,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] byte_count,
    output logic        busy,
    output logic        rx_err
);

    localparam int               CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BaudHalf  = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] BaudLast  = CNT_W'(BAUD_DIV - 1);
    localparam logic [15:0]      FrameLast = 16'(FRAME_BYTES);

    typedef enum logic [2:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP,
        BIT_BREAK
    } bitState_t;

    typedef enum logic {
        FR_HUNT,
        FR_PAYLOAD
    } frameState_t;

    logic             rxMeta_q, rxSync_q;
    bitState_t        bitState_q, bitState_d;
    logic [CNT_W-1:0] baudCnt_q, baudCnt_d;
    logic [2:0]       bitCnt_q, bitCnt_d;
    logic [7:0]       shift_q, shift_d;
    frameState_t      frameState_q, frameState_d;
    logic [3:0]       hdrIdx_q, hdrIdx_d;
    logic [15:0]      byteCnt_q, byteCnt_d;
    logic [7:0]       pixData_q, pixData_d;
    logic             pixValid_q, pixValid_d;
    logic             frameStart_q, frameStart_d;
    logic             frameDone_q, frameDone_d;
    logic             rxErr_q, rxErr_d;
    logic             byteDone;

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [16:0] TimeoutLast = 17'(TIMEOUT_CYC - 1);
    logic [16:0] idleCnt_q, idleCnt_d;
`endif

    function automatic logic [7:0] hdrByte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1: hdrByte = 8'h0A;
            4'd2:       hdrByte = 8'h4E;
            4'd3:       hdrByte = 8'h65;
            4'd4:       hdrByte = 8'h77;
            4'd5:       hdrByte = 8'h20;
            4'd6:       hdrByte = 8'h49;
            4'd7:       hdrByte = 8'h6D;
            4'd8:       hdrByte = 8'h67;
            4'd9:       hdrByte = 8'h0D;
            default:    hdrByte = 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q     <= 1'b1;
            rxSync_q     <= 1'b1;
            bitState_q   <= BIT_IDLE;
            baudCnt_q    <= '0;
            bitCnt_q     <= '0;
            shift_q      <= '0;
            frameState_q <= FR_HUNT;
            hdrIdx_q     <= '0;
            byteCnt_q    <= '0;
            pixData_q    <= '0;
            pixValid_q   <= 1'b0;
            frameStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
            rxErr_q      <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
            idleCnt_q    <= '0;
`endif
        end else begin
            rxMeta_q     <= rx;
            rxSync_q     <= rxMeta_q;
            bitState_q   <= bitState_d;
            baudCnt_q    <= baudCnt_d;
            bitCnt_q     <= bitCnt_d;
            shift_q      <= shift_d;
            frameState_q <= frameState_d;
            hdrIdx_q     <= hdrIdx_d;
            byteCnt_q    <= byteCnt_d;
            pixData_q    <= pixData_d;
            pixValid_q   <= pixValid_d;
            frameStart_q <= frameStart_d;
            frameDone_q  <= frameDone_d;
            rxErr_q      <= rxErr_d;
`ifdef UART_RX_TIMEOUT_EN
            idleCnt_q    <= idleCnt_d;
`endif
        end
    end

    always_comb begin
        bitState_d   = bitState_q;
        baudCnt_d    = baudCnt_q;
        bitCnt_d     = bitCnt_q;
        shift_d      = shift_q;
        frameState_d = frameState_q;
        hdrIdx_d     = hdrIdx_q;
        byteCnt_d    = byteCnt_q;
        pixData_d    = pixData_q;
        pixValid_d   = 1'b0;
        frameStart_d = 1'b0;
        frameDone_d  = 1'b0;
        rxErr_d      = 1'b0;
        byteDone     = 1'b0;
`ifdef UART_RX_TIMEOUT_EN
        idleCnt_d    = idleCnt_q;
`endif

        // Bit level: START is checked mid-bit, later samples land one full bit apart.
        case (bitState_q)
            BIT_IDLE: begin
                if (!rxSync_q) begin
                    bitState_d = BIT_START;
                    baudCnt_d  = '0;
                end
            end
            BIT_START: begin
                if (baudCnt_q == BaudHalf) begin
                    baudCnt_d  = '0;
                    bitCnt_d   = '0;
                    bitState_d = rxSync_q ? BIT_IDLE : BIT_DATA;
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BIT_DATA: begin
                if (baudCnt_q == BaudLast) begin
                    baudCnt_d = '0;
                    shift_d   = {rxSync_q, shift_q[7:1]};
                    if (bitCnt_q == 3'd7) begin
                        bitState_d = BIT_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BIT_STOP: begin
                if (baudCnt_q == BaudLast) begin
                    baudCnt_d = '0;
                    if (rxSync_q) begin
                        byteDone   = 1'b1;
                        bitState_d = BIT_IDLE;
                    end else begin
                        rxErr_d    = 1'b1;
                        bitState_d = BIT_BREAK;
                    end
                end else begin
                    baudCnt_d = baudCnt_q + 1'b1;
                end
            end
            BIT_BREAK: begin
                if (rxSync_q) begin
                    bitState_d = BIT_IDLE;
                end
            end
            default: bitState_d = BIT_IDLE;
        endcase

        // A stray "\n" may still be the start of a header, so it restarts the match at 1 (or keeps 2).
        case (frameState_q)
            FR_HUNT: begin
                if (byteDone) begin
                    if (shift_q == hdrByte(hdrIdx_q)) begin
                        if (hdrIdx_q == 4'd11) begin
                            frameStart_d = 1'b1;
                            byteCnt_d    = '0;
                            hdrIdx_d     = '0;
                            frameState_d = FR_PAYLOAD;
                        end else begin
                            hdrIdx_d = hdrIdx_q + 1'b1;
                        end
                    end else if (shift_q == 8'h0A) begin
                        hdrIdx_d = (hdrIdx_q == 4'd2) ? 4'd2 : 4'd1;
                    end else begin
                        hdrIdx_d = '0;
                    end
                end
            end
            FR_PAYLOAD: begin
                if (byteDone) begin
                    pixData_d  = shift_q;
                    pixValid_d = 1'b1;
                    byteCnt_d  = byteCnt_q + 16'd1;
                    if (byteCnt_q + 16'd1 == FrameLast) begin
                        frameDone_d  = 1'b1;
                        frameState_d = FR_HUNT;
                    end
                end
            end
            default: frameState_d = FR_HUNT;
        endcase

`ifdef UART_RX_TIMEOUT_EN
        // A stalled host drops the frame; byte_count is left as-is for debugging.
        if (frameState_q == FR_PAYLOAD && !byteDone) begin
            if (idleCnt_q == TimeoutLast) begin
                idleCnt_d    = '0;
                rxErr_d      = 1'b1;
                frameState_d = FR_HUNT;
            end else begin
                idleCnt_d = idleCnt_q + 17'd1;
            end
        end else begin
            idleCnt_d = '0;
        end
`endif
    end

    assign pix_data    = pixData_q;
    assign pix_valid   = pixValid_q;
    assign frame_start = frameStart_q;
    assign frame_done  = frameDone_q;
    assign byte_count  = byteCnt_q;
    assign busy        = (frameState_q == FR_PAYLOAD);
    assign rx_err      = rxErr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: randomized self-checking bench for uart_rx_frame, compared against
// a byte-level model of the header hunt and payload counting.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int BAUD  = 16;
    localparam int FRAME = 4;
    localparam int TOUT  = 500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] byte_count;
    logic        busy;
    logic        rx_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] hdrRef [12] = '{8'h0A, 8'h0A, 8'h4E, 8'h65, 8'h77, 8'h20,
                                8'h49, 8'h6D, 8'h67, 8'h0D, 8'h0A, 8'h0A};

    // Reference model state, advanced once per transmitted byte
    bit         mPayload = 1'b0;
    int         mIdx     = 0;
    int         mCount   = 0;
    int         expStarts = 0;
    int         expDones  = 0;
    int         expErrs   = 0;
    logic [7:0] expPix [$];

    // Observed DUT events
    int         obsStarts = 0;
    int         obsDones  = 0;
    int         obsErrs   = 0;
    int         obsLoneDone = 0;
    logic [7:0] obsPix [$];

    uart_rx_frame #(
        .BAUD_DIV   (BAUD),
        .FRAME_BYTES(FRAME),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .byte_count (byte_count),
        .busy       (busy),
        .rx_err     (rx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_valid) obsPix.push_back(pix_data);
        if (frame_start) obsStarts++;
        if (frame_done) obsDones++;
        if (frame_done && !pix_valid) obsLoneDone++;
        if (rx_err) obsErrs++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic modelByte(input logic [7:0] b, input bit stopOk);
        if (!stopOk) begin
            expErrs++;
        end else if (mPayload) begin
            expPix.push_back(b);
            mCount++;
            if (mCount == FRAME) begin
                expDones++;
                mPayload = 1'b0;
            end
        end else if (b == hdrRef[mIdx]) begin
            if (mIdx == 11) begin
                expStarts++;
                mCount   = 0;
                mIdx     = 0;
                mPayload = 1'b1;
            end else begin
                mIdx++;
            end
        end else if (b == 8'h0A) begin
            mIdx = (mIdx == 2) ? 2 : 1;
        end else begin
            mIdx = 0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input int gap);
        modelByte(b, stopOk);
        rx = 1'b0;
        waitCycles(BAUD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            waitCycles(BAUD);
        end
        rx = stopOk;
        waitCycles(BAUD);
        rx = 1'b1;
        if (!stopOk) waitCycles(BAUD);
        if (gap > 0) waitCycles(gap);
    endtask

    task automatic sendHeader(input int first);
        for (int i = first; i < 12; i++) applyStimulus(hdrRef[i], 1'b1, 0);
    endtask

    task automatic checkpoint(input string tag);
        waitCycles(2 * BAUD);
        checkOutput({tag, ".pixCount"}, obsPix.size(), expPix.size());
        for (int i = 0; i < expPix.size(); i++) begin
            if (i < obsPix.size()) checkOutput({tag, ".pix"}, obsPix[i], expPix[i]);
        end
        checkOutput({tag, ".starts"}, obsStarts, expStarts);
        checkOutput({tag, ".dones"}, obsDones, expDones);
        checkOutput({tag, ".errs"}, obsErrs, expErrs);
        checkOutput({tag, ".loneDone"}, obsLoneDone, 0);
        checkOutput({tag, ".byteCount"}, byte_count, mCount);
        checkOutput({tag, ".busy"}, busy, mPayload);
        obsPix.delete();
        expPix.delete();
    endtask

    task automatic doReset(input string tag);
        rst = 1'b1;
        waitCycles(3);
        checkOutput({tag, ".pix_data"}, pix_data, 0);
        checkOutput({tag, ".pix_valid"}, pix_valid, 0);
        checkOutput({tag, ".frame_start"}, frame_start, 0);
        checkOutput({tag, ".frame_done"}, frame_done, 0);
        checkOutput({tag, ".byte_count"}, byte_count, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".rx_err"}, rx_err, 0);
        mPayload = 1'b0;
        mIdx     = 0;
        mCount   = 0;
        rst = 1'b0;
        waitCycles(2);
    endtask

    initial begin
        int kind;
        int n;
        rx = 1'b1;
        doReset("reset");

        // Basic frame with boundary pixel values, header sent back to back
        sendHeader(0);
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'h55, 1'b1, 0);
        applyStimulus(8'hAA, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 0);
        checkpoint("frame");

        // Extra leading newline keeps the match alive
        applyStimulus(8'h0A, 1'b1, 2);
        sendHeader(0);
        for (int i = 0; i < FRAME; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1);
        checkpoint("tripleNl");

        // Header without the leading newlines must not sync
        sendHeader(2);
        for (int i = 0; i < FRAME; i++) applyStimulus(8'h30 + 8'(i), 1'b1, 0);
        checkpoint("noLead");

        // Framing error inside payload
        applyStimulus(8'h41, 1'b1, 0);
        sendHeader(0);
        applyStimulus(8'h11, 1'b1, 0);
        applyStimulus(8'h22, 1'b1, 0);
        applyStimulus(8'h3C, 1'b0, 0);
        checkpoint("framingErr");
        applyStimulus(8'h33, 1'b1, 0);
        applyStimulus(8'h44, 1'b1, 0);
        checkpoint("afterErr");

        // Short low glitch on an idle line
        rx = 1'b0;
        waitCycles(BAUD / 4);
        rx = 1'b1;
        checkpoint("glitch");

        // Header text inside payload is just data
        sendHeader(0);
        sendHeader(8);
        checkpoint("hdrInPayload");

        // Reset in the middle of a frame
        sendHeader(0);
        applyStimulus(8'h5A, 1'b1, 0);
        applyStimulus(8'hA5, 1'b1, 0);
        checkpoint("preRst");
        doReset("midRst");
        checkpoint("postRst");

`ifdef UART_RX_TIMEOUT_EN
        sendHeader(0);
        applyStimulus(8'h12, 1'b1, 0);
        applyStimulus(8'h34, 1'b1, 0);
        checkpoint("toStart");
        waitCycles(400);
        checkpoint("toBefore");
        waitCycles(100);
        expErrs++;
        mPayload = 1'b0;
        checkpoint("toAfter");
        doReset("toRst");
`endif

        for (int it = 0; it < 25; it++) begin
`ifdef UART_RX_TIMEOUT_EN
            kind = $urandom_range(0, 2);
`else
            kind = $urandom_range(0, 3);
`endif
            case (kind)
                0: sendHeader(0);
                1: sendHeader($urandom_range(0, 11));
                2: begin
                    n = $urandom_range(1, 6);
                    for (int j = 0; j < n; j++) begin
                        if ($urandom_range(0, 3) == 0)
                            applyStimulus(8'h0A, 1'b1, $urandom_range(0, 3));
                        else
                            applyStimulus(8'($urandom_range(0, 255)), 1'b1, $urandom_range(0, 3));
                    end
                end
                default: applyStimulus(8'($urandom_range(0, 255)), 1'b0, 0);
            endcase
            checkpoint("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
